// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: binary-to-BCD conversion and 4-digit multiplexed common-anode 7-segment scan.
module fnd_scan_driver #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGIT_HZ = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] seg_data,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        busy
);
  localparam int DIV = CLK_HZ / DIGIT_HZ;
  localparam int TW  = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state;
  logic [13:0] bin, last_val;
  logic [15:0] bcd, adj;
  logic [3:0]  it;
  logic        over_n, over;
  logic [3:0]  d [4];
  logic [TW-1:0] tick;
  logic [1:0]  idx;
  logic [3:0]  blank;
  logic [7:0]  code;
  function automatic logic [7:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0: seg_code = 8'hC0;
      4'd1: seg_code = 8'hF9;
      4'd2: seg_code = 8'hA4;
      4'd3: seg_code = 8'hB0;
      4'd4: seg_code = 8'h99;
      4'd5: seg_code = 8'h92;
      4'd6: seg_code = 8'h82;
      4'd7: seg_code = 8'hF8;
      4'd8: seg_code = 8'h80;
      4'd9: seg_code = 8'h90;
      default: seg_code = 8'hBF;
    endcase
  endfunction
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++)
      adj[i*4 +: 4] = bcd[i*4 +: 4] >= 4'd5 ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
  end
  // a digit blanks only if it and every higher digit are zero; the ones digit never blanks
  assign blank[3] = BLANK_LZ != 0 && !over && d[3] == 4'd0;
  assign blank[2] = blank[3] && d[2] == 4'd0;
  assign blank[1] = blank[2] && d[1] == 4'd0;
  assign blank[0] = 1'b0;
  assign code = over ? 8'hBF : seg_code(d[idx]);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bin      <= '0;
      last_val <= '0;
      bcd      <= '0;
      it       <= '0;
      over_n   <= 1'b0;
      over     <= 1'b0;
      d        <= '{default: 4'd0};
    end else begin
      case (state)
        IDLE: if (seg_data != last_val) begin
          bin      <= seg_data;
          last_val <= seg_data;
          over_n   <= seg_data > 14'd9999;
          bcd      <= '0;
          it       <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {adj, bin} << 1;
          it         <= it + 4'd1;
          if (it == 4'd13) state <= DONE;
        end
        DONE: begin
          d[0]  <= bcd[3:0];
          d[1]  <= bcd[7:4];
          d[2]  <= bcd[11:8];
          d[3]  <= bcd[15:12];
          over  <= over_n;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= '0;
      idx  <= '0;
      an   <= 4'b1111;
      seg  <= 8'hFF;
    end else begin
      tick <= tick == TW'(DIV - 1) ? '0 : tick + TW'(1);
      if (tick == TW'(DIV - 1)) idx <= idx + 2'd1;
      an   <= blank[idx] ? 4'b1111 : ~(4'b0001 << idx);
      seg  <= blank[idx] ? 8'hFF : code;
    end
  end
endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed checks of conversion latency, scan order, blanking and overrange.
module tb_fnd_scan_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] seg_data = '0;
  logic [3:0]  an, an_b;
  logic [7:0]  seg, seg_b;
  logic        busy, busy_b;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  fnd_scan_driver #(.CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .seg_data(seg_data), .an(an), .seg(seg), .busy(busy));
  fnd_scan_driver #(.CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_LZ(0)) dut_b (
    .clk(clk), .reset(reset), .seg_data(seg_data), .an(an_b), .seg(seg_b), .busy(busy_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_conv(input string tag);
    int n;
    step(1);
    chk({tag, "_busy_start"}, busy, 1'b1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step(1);
    end
    chk({tag, "_busy_len"}, n, 15);
    step(1);
  endtask
  task automatic check_slots(input bit alt, input logic [7:0] s0, s1, s2, s3,
                             input logic [3:0] bl, input string tag);
    logic [7:0] s [4];
    logic [3:0] ea;
    int n;
    s = '{s0, s1, s2, s3};
    n = 0;
    while ((alt ? an_b : an) == 4'b1110 && n < 50) begin
      n++;
      step(1);
    end
    while ((alt ? an_b : an) != 4'b1110 && n < 100) begin
      n++;
      step(1);
    end
    chk({tag, "_sync"}, alt ? an_b : an, 4'b1110);
    step(5);
    for (int k = 0; k < 4; k++) begin
      ea = ~(4'b0001 << k);
      chk($sformatf("%s_an%0d", tag, k), alt ? an_b : an, bl[k] ? 4'b1111 : ea);
      chk($sformatf("%s_seg%0d", tag, k), alt ? seg_b : seg, bl[k] ? 8'hFF : s[k]);
      step(10);
    end
  endtask
  initial begin
    int n;
    logic [7:0] e;
    step(2);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step(1);
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 8'hC0);
    chk("first_busy", busy, 1'b0);
    check_slots(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b1110, "zero");
    chk("zero_busy", busy, 1'b0);
    check_slots(1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000, "zero_b");
    seg_data = 14'd1234;
    wait_conv("c1234");
    check_slots(0, 8'h99, 8'hB0, 8'hA4, 8'hF9, 4'b0000, "v1234");
    seg_data = 14'd9999;
    wait_conv("c9999");
    check_slots(0, 8'h90, 8'h90, 8'h90, 8'h90, 4'b0000, "v9999");
    seg_data = 14'd0;
    wait_conv("c0");
    check_slots(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b1110, "v0");
    check_slots(1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b0000, "v0_b");
    seg_data = 14'd42;
    wait_conv("c42");
    check_slots(0, 8'hA4, 8'h99, 8'hC0, 8'hC0, 4'b1100, "v42");
    check_slots(1, 8'hA4, 8'h99, 8'hC0, 8'hC0, 4'b0000, "v42_b");
    seg_data = 14'd16383;
    wait_conv("c16383");
    check_slots(0, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 4'b0000, "v16383");
    check_slots(1, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 4'b0000, "v16383_b");
    seg_data = 14'd10000;
    wait_conv("c10000");
    check_slots(0, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 4'b0000, "v10000");
    seg_data = 14'd1234;
    step(1);
    chk("ovl_busy1", busy, 1'b1);
    step(4);
    seg_data = 14'd5678;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step(1);
    end
    chk("ovl_rest", n, 11);
    step(1);
    chk("ovl_recapture", busy, 1'b1);
    e = an == 4'b1110 ? 8'h99 : an == 4'b1101 ? 8'hB0 : an == 4'b1011 ? 8'hA4 :
        an == 4'b0111 ? 8'hF9 : 8'h00;
    chk("ovl_mid1234", seg, e);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step(1);
    end
    chk("ovl_len2", n, 15);
    step(1);
    check_slots(0, 8'h80, 8'hF8, 8'h82, 8'h92, 4'b0000, "v5678");
    seg_data = 14'd1111;
    step(3);
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("areset_busy", busy, 1'b0);
    chk("areset_an", an, 4'b1111);
    chk("areset_seg", seg, 8'hFF);
    step(2);
    reset = 1'b0;
    step(1);
    chk("rel_an", an, 4'b1110);
    chk("rel_seg", seg, 8'hC0);
    chk("rel_busy", busy, 1'b1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step(1);
    end
    chk("rel_len", n, 15);
    step(1);
    check_slots(0, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 4'b0000, "v1111");
    chk("b_busy_end", busy_b, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
- Receiving end of the 14-bit `seg_data` bus produced by the mode/counter control block.
- Converts the binary value (0..9999) to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto the board's 4-digit common-anode 7-segment display: active-low anodes, active-low segments.
- Sits between the control block and the top-level FND pins.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- DIGIT_HZ, 1000, per-digit scan rate; digit advances every CLK_HZ/DIGIT_HZ clocks.
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = always show all four digits.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- seg_data  input  14  unsigned binary value to display; valid display range 0..9999.
- an  output  4  digit anodes, active low, one-hot-low; an[0] = ones digit, an[3] = thousands.
- seg  output  8  segments, active low; seg[7] = dp, seg[6:0] = g,f,e,d,c,b,a.
- busy  output  1  high while a conversion is in progress (SHIFT or DONE state).

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk. All registers are cleared asynchronously.
- Reset values:
  - an = 4'b1111, seg = 8'hFF, busy = 0.
  - digit regs d0..d3 = 0, last_val = 0, over = 0.
  - scan index = 0, tick counter = 0, FSM = IDLE.
- Converter FSM:
  - IDLE: if seg_data != last_val, capture seg_data into shift reg and last_val. Set over_n = (seg_data > 9999). Clear the BCD accumulator. Go to SHIFT.
  - SHIFT: 14 cycles, one iteration per clock. Add 3 to each BCD nibble that is >= 5, then shift {bcd, bin} left by 1. After the 14th iteration go to DONE.
  - DONE: 1 cycle. Load d0..d3 from the accumulator and load over from over_n, then return to IDLE.
  - busy = (state != IDLE).
- Latency: capture edge -> digit regs updated at capture + 15 clocks (14 SHIFT + 1 DONE). The next IDLE cycle can capture again.
- Input changes while busy are ignored until IDLE. IDLE then compares against last_val, so the final value always gets displayed. Intermediate values may be skipped.
- Overrange: if over = 1, every digit displays a dash (seg = 8'hBF) and blanking is suppressed.
- Scan timing:
  - Tick counter runs 0..CLK_HZ/DIGIT_HZ-1 and wraps.
  - On the wrap, the scan index advances 0 -> 1 -> 2 -> 3 -> 0.
  - The tick counter and scan index run continuously and are independent of the converter.
- Outputs are registered and updated every clock from the current index and digit regs.
  - First posedge after reset release: an = 4'b1110.
  - an = ~(4'b0001 << index).
- Leading-zero blanking (BLANK_LZ = 1):
  - Digit k > 0 is blanked if dk and all higher digits are 0.
  - A blanked digit drives an = 4'b1111 and seg = 8'hFF for its slot.
  - Digit 0 is never blanked, so value 0 shows "0".
- Segment codes (dp off), hex: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF.
- dp is always 1 (off).
- Reset mid-conversion: FSM returns to IDLE and the digits clear to 0 immediately. After release, seg_data != 0 triggers a fresh conversion.

Test Plan:
(Bench uses CLK_HZ = 1000, DIGIT_HZ = 100, so each digit slot is 10 clocks.)
1. Reset held -> an = 1111, seg = FF. Release with seg_data = 0 -> slot 0: an = 1110, seg = C0; slots 1-3: an = 1111, seg = FF; busy stays 0.
2. seg_data = 1234 -> busy high 15 clocks. Then slots cycle: an = 1110/seg = 99, an = 1101/seg = B0, an = 1011/seg = A4, an = 0111/seg = F9.
3. seg_data = 9999 -> all four slots seg = 90. Then seg_data = 0 -> slot 0 seg = C0, slots 1-3 blanked (an = 1111).
4. seg_data = 42, BLANK_LZ = 1 -> slot 0 A4, slot 1 99, slots 2-3 blanked. With BLANK_LZ = 0 -> slots 2-3 show C0.
5. seg_data = 16383 -> after 15 clocks, all slots seg = BF with all anodes scanned. Then seg_data = 10000 -> still BF.
6. seg_data = 1234, then 5678 at capture + 5 -> digits show 1234 at capture + 15, then 5678 within a further 16 clocks. Async reset asserted mid-SHIFT -> digits read 0 and busy = 0 immediately.
